// File: rtl/rf_arbiter_pkg.sv
// Shared types for the register-file arbiter.
//   rf_cmd_t    : command encoding driven on rf_signal towards REG_FILE
//   arb_state_t : arbiter FSM states
//   reg_idx_t   : 5-bit architectural register index
package rf_arbiter_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RF_NOP   = 2'b00,
        RF_READ  = 2'b01,
        RF_WRITE = 2'b10
    } rf_cmd_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_arbiter_if.sv
// Bundle of everything the arbiter talks to besides clk/rst/rdy_in.
//   ID side : id_req, id_rs1, id_rs2 -> id_ack, id_rs1_data, id_rs2_data
//   WB side : wb_req, wb_rd, wb_data -> wb_ack
//   RF side : rf_signal, rf_rs1, rf_rs2, rf_rd, rf_data -> rf_rs1_data, rf_rs2_data
// slave  : the arbiter's view.
// master : the surrounding stages and REG_FILE (the opposite directions).
interface rf_arbiter_if import rf_arbiter_pkg::*; #(
    parameter int LEN = 32
);
    logic            id_req;
    reg_idx_t        id_rs1;
    reg_idx_t        id_rs2;
    logic            id_ack;
    logic [LEN-1:0]  id_rs1_data;
    logic [LEN-1:0]  id_rs2_data;

    logic            wb_req;
    reg_idx_t        wb_rd;
    logic [LEN-1:0]  wb_data;
    logic            wb_ack;

    rf_cmd_t         rf_signal;
    reg_idx_t        rf_rs1;
    reg_idx_t        rf_rs2;
    reg_idx_t        rf_rd;
    logic [LEN-1:0]  rf_data;
    logic [LEN-1:0]  rf_rs1_data;
    logic [LEN-1:0]  rf_rs2_data;

    modport slave (
        input  id_req, id_rs1, id_rs2, wb_req, wb_rd, wb_data, rf_rs1_data, rf_rs2_data,
        output id_ack, id_rs1_data, id_rs2_data, wb_ack,
               rf_signal, rf_rs1, rf_rs2, rf_rd, rf_data
    );

    modport master (
        output id_req, id_rs1, id_rs2, wb_req, wb_rd, wb_data, rf_rs1_data, rf_rs2_data,
        input  id_ack, id_rs1_data, id_rs2_data, wb_ack,
               rf_signal, rf_rs1, rf_rs2, rf_rd, rf_data
    );

endinterface

// File: rtl/rf_arbiter.sv
// Register-file arbiter: shares the single REG_FILE command port between the
// decode read requester (ID) and the write-back requester (WB). WB always wins
// when both are eligible, so a read issued alongside a write sees the new value.
// Ports:
//   clk    : clock, all state on posedge
//   rst    : asynchronous, active-high reset
//   rdy_in : global ready; low freezes every register including ack pulses
//   bus    : ID / WB / REG_FILE signals (rf_arbiter_if.slave)
// Every rf_* output and every ack/data output comes straight from a register.
module rf_arbiter import rf_arbiter_pkg::*; #(
    parameter int LEN    = 32,
    parameter int RF_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy_in,
    rf_arbiter_if.slave bus
);

    localparam int                LAT_W    = (RF_LAT > 1) ? $clog2(RF_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RF_LAT - 1);

    typedef struct packed {
        arb_state_t      state;
        logic [LAT_W-1:0] lat_cnt;
        logic            owner_wr;   // command in flight belongs to WB
        rf_cmd_t         cmd;
        reg_idx_t        rs1;
        reg_idx_t        rs2;
        reg_idx_t        rd;
        logic [LEN-1:0]  wdata;
        logic            id_ack;
        logic            wb_ack;
        logic [LEN-1:0]  rs1_data;
        logic [LEN-1:0]  rs2_data;
    } regs_t;

    regs_t r, r_n;
    logic  wb_elig, id_elig;

    // A requester whose ack is still high is finishing its handshake and must
    // not be granted again on the same level request.
    assign wb_elig = bus.wb_req && !r.wb_ack;
    assign id_elig = bus.id_req && !r.id_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (rdy_in) begin
            r <= r_n;
        end
    end

    always_comb begin
        r_n        = r;
        r_n.id_ack = 1'b0;
        r_n.wb_ack = 1'b0;
        case (r.state)
            ARB_IDLE: begin
                if (wb_elig) begin
                    if (bus.wb_rd == '0) begin
                        // x0 is hardwired zero: acknowledge without touching REG_FILE
                        r_n.wb_ack = 1'b1;
                    end else begin
                        r_n.cmd      = RF_WRITE;
                        r_n.rd       = bus.wb_rd;
                        r_n.wdata    = bus.wb_data;
                        r_n.lat_cnt  = LAT_INIT;
                        r_n.owner_wr = 1'b1;
                        r_n.state    = ARB_BUSY;
                    end
                end else if (id_elig) begin
                    r_n.cmd      = RF_READ;
                    r_n.rs1      = bus.id_rs1;
                    r_n.rs2      = bus.id_rs2;
                    r_n.lat_cnt  = LAT_INIT;
                    r_n.owner_wr = 1'b0;
                    r_n.state    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (r.lat_cnt != '0) begin
                    r_n.lat_cnt = r.lat_cnt - LAT_W'(1);
                end else begin
                    r_n.cmd   = RF_NOP;
                    r_n.state = ARB_IDLE;
                    if (r.owner_wr) begin
                        r_n.wb_ack = 1'b1;
                    end else begin
                        r_n.id_ack   = 1'b1;
                        r_n.rs1_data = (r.rs1 == '0) ? '0 : bus.rf_rs1_data;
                        r_n.rs2_data = (r.rs2 == '0) ? '0 : bus.rf_rs2_data;
                    end
                end
            end
            default: r_n.state = ARB_IDLE;
        endcase
    end

    assign bus.rf_signal   = r.cmd;
    assign bus.rf_rs1      = r.rs1;
    assign bus.rf_rs2      = r.rs2;
    assign bus.rf_rd       = r.rd;
    assign bus.rf_data     = r.wdata;
    assign bus.id_ack      = r.id_ack;
    assign bus.wb_ack      = r.wb_ack;
    assign bus.id_rs1_data = r.rs1_data;
    assign bus.id_rs2_data = r.rs2_data;

endmodule

// File: tb/tb_rf_arbiter.sv
// Self-checking bench for rf_arbiter. Two instances: RF_LAT=1 (main) and
// RF_LAT=3. Each has a small behavioural REG_FILE attached; expected read
// data comes from a separate architectural register array updated as writes
// are issued, expected latencies from the handshake timing rules.
module tb_rf_arbiter;
    import rf_arbiter_pkg::*;

    localparam int LEN = 32;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rdy_in = 1'b1;

    always #5 clk = ~clk;

    rf_arbiter_if #(.LEN(LEN)) bus_a ();
    rf_arbiter_if #(.LEN(LEN)) bus_b ();

    rf_arbiter #(.LEN(LEN), .RF_LAT(1)) dut_a (.clk(clk), .rst(rst), .rdy_in(rdy_in), .bus(bus_a));
    rf_arbiter #(.LEN(LEN), .RF_LAT(3)) dut_b (.clk(clk), .rst(rst), .rdy_in(rdy_in), .bus(bus_b));

    // REG_FILE stand-ins: synchronous write, combinational read.
    // x0 holds a nonzero pattern so a forced-zero read is actually observable.
    logic [LEN-1:0] mem_a [32];
    logic [LEN-1:0] mem_b [32];
    bit init_a = 1'b0;
    bit init_b = 1'b0;

    always @(posedge clk) begin
        if (!init_a) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= 32'hC0DE_0000 | 32'(i);
            init_a <= 1'b1;
        end else if (bus_a.rf_signal == RF_WRITE) begin
            mem_a[bus_a.rf_rd] <= bus_a.rf_data;
        end
    end

    always @(posedge clk) begin
        if (!init_b) begin
            for (int j = 0; j < 32; j++) mem_b[j] <= 32'hC0DE_0000 | 32'(j);
            init_b <= 1'b1;
        end else if (bus_b.rf_signal == RF_WRITE) begin
            mem_b[bus_b.rf_rd] <= bus_b.rf_data;
        end
    end

    assign bus_a.rf_rs1_data = mem_a[bus_a.rf_rs1];
    assign bus_a.rf_rs2_data = mem_a[bus_a.rf_rs2];
    assign bus_b.rf_rs1_data = mem_b[bus_b.rf_rs1];
    assign bus_b.rf_rs2_data = mem_b[bus_b.rf_rs2];

    // Architectural view: what a program would read back from each register.
    logic [LEN-1:0] arch [32];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One transaction on the RF_LAT=1 instance, started just after a negedge
    // with the arbiter idle. Latencies are counted in clock edges from the
    // grant opportunity edge to the edge at which the ack is first seen.
    task automatic xact(input string tag, input bit do_wr, input logic [4:0] rd,
                        input logic [31:0] wd, input bit do_rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        int wn, rn, exp_wn, exp_rn;
        bit saw_wr, done;
        logic [31:0] e1, e2;
        wn = 0; rn = 0; saw_wr = 1'b0; done = 1'b0;
        // x0 write: ack next cycle; real write: command cycle + ack cycle.
        exp_wn = (rd == 5'd0) ? 1 : 2;
        // Write is served first, so a concurrent read sees the new value.
        if (do_wr && rd != 5'd0) arch[rd] = wd;
        e1 = arch[rs1];
        e2 = arch[rs2];
        exp_rn = (do_wr ? exp_wn : 0) + 2;
        bus_a.wb_req = do_wr; bus_a.wb_rd = rd; bus_a.wb_data = wd;
        bus_a.id_req = do_rd; bus_a.id_rs1 = rs1; bus_a.id_rs2 = rs2;
        for (int n = 1; n <= 30 && !done; n++) begin
            @(negedge clk);
            if (bus_a.rf_signal == RF_WRITE) saw_wr = 1'b1;
            if (wn != 0 && n == wn + 1) chk({tag, " wb_ack pulse"}, 64'(bus_a.wb_ack), 64'd0);
            if (rn != 0 && n == rn + 1) chk({tag, " id_ack pulse"}, 64'(bus_a.id_ack), 64'd0);
            if (do_wr && wn == 0 && bus_a.wb_ack) begin wn = n; bus_a.wb_req = 1'b0; end
            if (do_rd && rn == 0 && bus_a.id_ack) begin rn = n; bus_a.id_req = 1'b0; end
            done = (!do_wr || (wn != 0 && n > wn)) && (!do_rd || (rn != 0 && n > rn));
        end
        bus_a.wb_req = 1'b0;
        bus_a.id_req = 1'b0;
        if (do_wr) chk({tag, " wb latency"}, 64'(wn), 64'(exp_wn));
        if (do_rd) begin
            chk({tag, " id latency"}, 64'(rn), 64'(exp_rn));
            chk({tag, " rs1_data"}, 64'(bus_a.id_rs1_data), 64'(e1));
            chk({tag, " rs2_data"}, 64'(bus_a.id_rs2_data), 64'(e2));
        end
        chk({tag, " write cmd issued"}, 64'(saw_wr), 64'(do_wr && rd != 5'd0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w, rd_en;
        logic [4:0]  rrd, rs1, rs2;
        logic [31:0] d;
        int          got, nread;

        for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'd0 : (32'hC0DE_0000 | 32'(i));
        bus_a.id_req = 1'b0; bus_a.id_rs1 = '0; bus_a.id_rs2 = '0;
        bus_a.wb_req = 1'b0; bus_a.wb_rd  = '0; bus_a.wb_data = '0;
        bus_b.id_req = 1'b0; bus_b.id_rs1 = '0; bus_b.id_rs2 = '0;
        bus_b.wb_req = 1'b0; bus_b.wb_rd  = '0; bus_b.wb_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst rf_signal", 64'(bus_a.rf_signal), 64'(RF_NOP));
        chk("rst id_ack", 64'(bus_a.id_ack), 64'd0);
        chk("rst wb_ack", 64'(bus_a.wb_ack), 64'd0);
        chk("rst rs1_data", 64'(bus_a.id_rs1_data), 64'd0);
        chk("rst rf_rd", 64'(bus_a.rf_rd), 64'd0);
        chk("rst rf_data", 64'(bus_a.rf_data), 64'd0);
        chk("rst state", 64'(dut_a.r.state), 64'(ARB_IDLE));
        chk("rst b rf_signal", 64'(bus_b.rf_signal), 64'(RF_NOP));
        rst = 1'b0;
        @(negedge clk);

        // Reset while a write is in flight: abandoned, no ack, x5 untouched
        bus_a.wb_req = 1'b1; bus_a.wb_rd = 5'd5; bus_a.wb_data = 32'h55AA_55AA;
        @(negedge clk);
        chk("midrst granted", 64'(bus_a.rf_signal), 64'(RF_WRITE));
        rst = 1'b1;
        bus_a.wb_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst wb_ack", 64'(bus_a.wb_ack), 64'd0);
            chk("midrst rf_signal", 64'(bus_a.rf_signal), 64'(RF_NOP));
            chk("midrst state", 64'(dut_a.r.state), 64'(ARB_IDLE));
        end
        chk("midrst x5 kept", 64'(mem_a[5]), 64'(arch[5]));
        rst = 1'b0;
        @(negedge clk);
        xact("midrst rd5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);

        // Write then read, rs2 = x0
        xact("wr3", 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        xact("rd3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0);

        // Same-cycle requests: write first, read observes it
        xact("sim7", 1'b1, 5'd7, 32'h0000_0011, 1'b1, 5'd7, 5'd3);

        // x0 write: immediate ack, no RF command, reads back zero
        xact("x0w", 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 5'd0);
        xact("x0r", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

        // rdy_in low for 3 cycles while BUSY; wb_data changes after grant
        d = $urandom;
        arch[9] = d;
        bus_a.wb_req = 1'b1; bus_a.wb_rd = 5'd9; bus_a.wb_data = d;
        @(negedge clk);
        chk("stall granted", 64'(bus_a.rf_signal), 64'(RF_WRITE));
        chk("stall lat_cnt", 64'(dut_a.r.lat_cnt), 64'd0);
        rdy_in = 1'b0;
        bus_a.wb_data = ~d;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall rf_signal hold", 64'(bus_a.rf_signal), 64'(RF_WRITE));
            chk("stall lat_cnt hold", 64'(dut_a.r.lat_cnt), 64'd0);
            chk("stall no ack", 64'(bus_a.wb_ack), 64'd0);
        end
        rdy_in = 1'b1;
        got = 0;
        for (int n = 5; n <= 20 && got == 0; n++) begin
            @(negedge clk);
            if (bus_a.wb_ack) got = n;
        end
        chk("stall ack latency", 64'(got), 64'd5);
        bus_a.wb_req = 1'b0;
        // A pending ack is frozen with everything else
        rdy_in = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall ack held", 64'(bus_a.wb_ack), 64'd1);
        end
        rdy_in = 1'b1;
        @(negedge clk);
        chk("stall ack drop", 64'(bus_a.wb_ack), 64'd0);
        xact("stall rd9", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd3);

        // Random mix of writes, reads and same-cycle pairs
        for (int t = 0; t < 24; t++) begin
            w     = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            if (!w && !rd_en) rd_en = 1'b1;
            rrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            d   = $urandom;
            xact($sformatf("rnd%0d", t), w, rrd, d, rd_en, rs1, rs2);
        end

        // RF_LAT=3: READ held 3 cycles, ack seen 4 edges after grant edge
        bus_b.id_req = 1'b1; bus_b.id_rs1 = 5'd1; bus_b.id_rs2 = 5'd2;
        got = 0; nread = 0;
        for (int n = 1; n <= 20 && got == 0; n++) begin
            @(negedge clk);
            if (bus_b.rf_signal == RF_READ) nread++;
            if (bus_b.id_ack) begin got = n; bus_b.id_req = 1'b0; end
        end
        chk("lat3 read cycles", 64'(nread), 64'd3);
        chk("lat3 ack latency", 64'(got), 64'd4);
        chk("lat3 rs1_data", 64'(bus_b.id_rs1_data), 64'h0000_0000_C0DE_0001);
        chk("lat3 rs2_data", 64'(bus_b.id_rs2_data), 64'h0000_0000_C0DE_0002);
        @(negedge clk);
        chk("lat3 ack pulse", 64'(bus_b.id_ack), 64'd0);
        chk("lat3 rf idle", 64'(bus_b.rf_signal), 64'(RF_NOP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
